truth_table_sequencer: RTL and testbench
========================================

Name: truth_table_sequencer

Overview:
- Sequences a 4-input / 2-output combinational block (inputs a,b,c,d; outputs y,z) through all 2^NUM_IN input combinations in ascending binary order.
- Holds each vector for a programmable number of cycles, then samples the block's outputs at the end of the hold window.
- Captures the full response table and compares it against a supplied expected table. Reports per-vector mismatches and an error count.
- Sits between a host/test controller (start/abort handshake) and the combinational datapath.

Parameters:
- NUM_IN, 4, number of datapath inputs; the sweep covers 2^NUM_IN vectors.
- NUM_OUT, 2, number of datapath outputs sampled per vector.
- HOLD_CYCLES, 10, cycles each vector is held (legal range is 1 and up).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE
- abort  in  1  stop the sweep; sampled only in RUN
- obs  in  NUM_OUT  datapath outputs; obs[1]=y, obs[0]=z
- exp_table  in  NUM_OUT*2^NUM_IN  expected outputs; entry i at [i*NUM_OUT +: NUM_OUT]; must be stable while busy
- stim  out  NUM_IN  datapath inputs; stim[3]=a, stim[2]=b, stim[1]=c, stim[0]=d
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when a sweep completes
- result_table  out  NUM_OUT*2^NUM_IN  captured obs per vector, same layout as exp_table
- mismatch_vec  out  2^NUM_IN  bit i set when entry i differs from expected
- err_cnt  out  NUM_IN+1  count of mismatching vectors (0 to 2^NUM_IN)

Behaviour:
- Reset: the following outputs are 0 on the first edge with rst=1:
  - stim, busy, done, result_table, mismatch_vec, err_cnt
  - internal idx and hold counter
  - state goes to IDLE
- Reset overrides everything, including a sweep in progress.
- FSM states: IDLE and RUN. done is a registered pulse, not a separate state.
- IDLE with start=1 at edge E:
  - state goes to RUN; busy=1, idx=0, hold=0, stim=0.
  - result_table, mismatch_vec and err_cnt clear to 0.
- RUN, each edge:
  - If hold < HOLD_CYCLES-1: hold increments.
  - Otherwise (sample edge):
    - result_table entry idx takes obs.
    - If obs differs from exp_table entry idx: mismatch_vec[idx] is set and err_cnt increments.
    - hold returns to 0.
    - If idx is not the last vector: idx and stim increment.
    - If idx = 2^NUM_IN-1: state goes to IDLE, busy=0, stim=0, done=1.
- Timing:
  - stim always equals idx while in RUN.
  - Each vector is presented for exactly HOLD_CYCLES cycles and sampled on the last edge of its window. The datapath is combinational, so no extra settle cycles.
  - done is high for exactly one cycle, starting 2^NUM_IN * HOLD_CYCLES cycles after edge E.
- Wrap-around: idx never wraps. The sweep terminates at the last vector.
- start while busy is ignored, including on the final sample edge.
- abort=1 in RUN at any edge, including a sample edge:
  - abort wins; no sample is taken on that edge.
  - state goes to IDLE, busy=0, stim=0.
  - done stays 0. Partial results are held.
- abort in IDLE is ignored. start and abort asserted together in IDLE means start.
- After completion, result_table, mismatch_vec and err_cnt hold until the next start or reset.
- Width rule: err_cnt is NUM_IN+1 bits, so all 2^NUM_IN mismatching cannot overflow.

Decomposition:
- Shared package `tts_pkg` holds:
  - state encoding: IDLE=1'b0, RUN=1'b1
  - localparams NUM_VEC = 2^NUM_IN and HOLD_W = clog2(HOLD_CYCLES) with a minimum of 1
- One natural sub-module: `hold_timer`.
  - Modulo-HOLD_CYCLES counter with a clear input and a `last` output.
  - The FSM uses `last` to qualify the sample edge.
- Capture, compare and count stay in the top module.

Test Plan:
- Reset: assert rst for 2 cycles, mid-stream after a partial run -> stim=0, busy=0, done=0, err_cnt=0, result_table=0.
- Full sweep:
  - Setup: HOLD_CYCLES=2; bench model y=a&b, z=c^d; exp_table matches the model.
  - Drive a 1-cycle start pulse.
  - Check stim steps 0,0,1,1,…,15,15.
  - Check done pulses exactly 32 cycles after the start edge.
  - Check err_cnt=0, mismatch_vec=16'h0000.
  - Check result entry 13 (a=1,b=1,c=0,d=1) = 2'b11.
- Mismatch: same run with expected entry 5 corrupted to 2'b11 (true value 2'b01) -> mismatch_vec=16'h0020, err_cnt=1.
- Abort:
  - Assert abort while stim=7.
  - Check busy=0 and stim=0 next cycle; done never asserts.
  - Check entries 0–6 are captured and entries 7–15 are 0.
- Start during busy: pulse start at vectors 3 and 15 -> no restart; done still exactly once at cycle 32.
- HOLD_CYCLES=1 and all-zero obs with all-ones expected table -> done at cycle 16, err_cnt=16, mismatch_vec=16'hFFFF.

Source files
------------

// File: rtl/tts_pkg.sv
// Shared definitions for the truth-table sequencer: FSM encoding and sizing helpers.
package tts_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int vec_count(input int num_in);
    return 1 << num_in;
  endfunction

  // A single-cycle hold still needs a 1-bit counter so the port width is never zero.
  function automatic int hold_width(input int hold_cycles);
    return (hold_cycles <= 1) ? 1 : $clog2(hold_cycles);
  endfunction

  localparam int DEF_NUM_IN      = 4;
  localparam int DEF_HOLD_CYCLES = 10;
  localparam int NUM_VEC         = vec_count(DEF_NUM_IN);
  localparam int HOLD_W          = hold_width(DEF_HOLD_CYCLES);

endpackage

// File: rtl/truth_table_sequencer_hold_timer.sv
// Modulo-HOLD_CYCLES counter; 'last' flags the final cycle of each hold window.
module hold_timer #(
  parameter int HOLD_CYCLES = 10,
  parameter int W           = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [W-1:0] cnt;

  assign last = (cnt == W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (last) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all input vectors through a combinational block, captures its response
// at the end of each hold window and scores it against an expected table.
module truth_table_sequencer
  import tts_pkg::*;
#(
  parameter int NUM_IN      = 4,
  parameter int NUM_OUT     = 2,
  parameter int HOLD_CYCLES = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic [NUM_OUT-1:0]                obs,
  input  logic [NUM_OUT*(1<<NUM_IN)-1:0]    exp_table,
  output logic [NUM_IN-1:0]                 stim,
  output logic                              busy,
  output logic                              done,
  output logic [NUM_OUT*(1<<NUM_IN)-1:0]    result_table,
  output logic [(1<<NUM_IN)-1:0]            mismatch_vec,
  output logic [NUM_IN:0]                   err_cnt
);

  localparam int VECS  = vec_count(NUM_IN);
  localparam int CNT_W = hold_width(HOLD_CYCLES);
  localparam logic [NUM_IN-1:0] LAST_IDX = NUM_IN'(VECS - 1);

  state_t            state;
  logic [NUM_IN-1:0] idx;
  logic              last;
  logic              timer_clr;
  logic              timer_en;

  // Holding the timer cleared outside RUN guarantees every sweep starts at hold=0.
  assign timer_clr = (state != RUN) || abort;
  assign timer_en  = (state == RUN);

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .W           (CNT_W)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .en   (timer_en),
    .last (last)
  );

  // idx returns to 0 whenever RUN is left, so stim can follow it directly.
  assign stim = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_table <= '0;
      mismatch_vec <= '0;
      err_cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= RUN;
            busy         <= 1'b1;
            idx          <= '0;
            result_table <= '0;
            mismatch_vec <= '0;
            err_cnt      <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            idx   <= '0;
          end else if (last) begin
            result_table[idx*NUM_OUT +: NUM_OUT] <= obs;
            if (obs != exp_table[idx*NUM_OUT +: NUM_OUT]) begin
              mismatch_vec[idx] <= 1'b1;
              err_cnt           <= err_cnt + 1'b1;
            end
            if (idx == LAST_IDX) begin
              state <= IDLE;
              busy  <= 1'b0;
              idx   <= '0;
              done  <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench: y=a&b, z=c^d datapath on a HOLD_CYCLES=2 instance, and a
// constant-zero datapath on a HOLD_CYCLES=1 instance.
module tb_truth_table_sequencer;

  typedef struct {
    logic [3:0] vec;
    logic [1:0] yz;
  } vec_rec_t;

  logic        clk;
  logic        rst;
  logic        start2, abort2, start1, abort1;
  logic [1:0]  obs2, obs1;
  logic [31:0] exp2, exp1;
  logic [3:0]  stim2, stim1;
  logic        busy2, busy1, done2, done1;
  logic [31:0] res2, res1;
  logic [15:0] mm2, mm1;
  logic [4:0]  err2, err1;

  int n_chk  = 0;
  int n_fail = 0;
  vec_rec_t tbl [16];

  truth_table_sequencer #(.NUM_IN(4), .NUM_OUT(2), .HOLD_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .obs(obs2),
    .exp_table(exp2), .stim(stim2), .busy(busy2), .done(done2),
    .result_table(res2), .mismatch_vec(mm2), .err_cnt(err2)
  );

  truth_table_sequencer #(.NUM_IN(4), .NUM_OUT(2), .HOLD_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .obs(obs1),
    .exp_table(exp1), .stim(stim1), .busy(busy1), .done(done1),
    .result_table(res1), .mismatch_vec(mm1), .err_cnt(err1)
  );

  assign obs2 = {stim2[3] & stim2[2], stim2[1] ^ stim2[0]};
  assign obs1 = 2'b00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic build_good_exp();
    for (int i = 0; i < 16; i++) exp2[i*2 +: 2] = tbl[i].yz;
  endtask

  // Called right after a negedge; leaves the caller at the negedge after the start edge.
  task automatic pulse_start2();
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  // Observation c follows edge E+c, where E is the start edge.
  task automatic sweep2(input bit poke_start, input string tag);
    int dones;
    dones = 0;
    pulse_start2();
    for (int c = 0; c < 36; c++) begin
      chk({tag, "_stim"}, {28'd0, stim2}, (c < 32) ? c / 2 : 0);
      chk({tag, "_busy"}, {31'd0, busy2}, {31'd0, (c < 32)});
      chk({tag, "_done"}, {31'd0, done2}, {31'd0, (c == 32)});
      if (done2) dones++;
      if (poke_start) start2 = (c == 6) || (c == 30) || (c == 31);
      @(negedge clk);
    end
    start2 = 1'b0;
    chk({tag, "_done_count"}, dones, 1);
  endtask

  initial begin
    tbl[0]  = '{4'd0,  2'b00}; tbl[1]  = '{4'd1,  2'b01};
    tbl[2]  = '{4'd2,  2'b01}; tbl[3]  = '{4'd3,  2'b00};
    tbl[4]  = '{4'd4,  2'b00}; tbl[5]  = '{4'd5,  2'b01};
    tbl[6]  = '{4'd6,  2'b01}; tbl[7]  = '{4'd7,  2'b00};
    tbl[8]  = '{4'd8,  2'b00}; tbl[9]  = '{4'd9,  2'b01};
    tbl[10] = '{4'd10, 2'b01}; tbl[11] = '{4'd11, 2'b00};
    tbl[12] = '{4'd12, 2'b10}; tbl[13] = '{4'd13, 2'b11};
    tbl[14] = '{4'd14, 2'b11}; tbl[15] = '{4'd15, 2'b10};

    rst = 1'b1; start2 = 0; abort2 = 0; start1 = 0; abort1 = 0;
    exp1 = 32'hFFFF_FFFF;
    build_good_exp();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stim", {28'd0, stim2}, 0);
    chk("rst_busy", {31'd0, busy2}, 0);
    chk("rst_done", {31'd0, done2}, 0);
    chk("rst_err",  {27'd0, err2}, 0);
    chk("rst_res",  res2, 0);
    chk("rst_mm",   {16'd0, mm2}, 0);
    chk("rst_busy1", {31'd0, busy1}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Full sweep with matching expectations
    sweep2(1'b0, "full");
    chk("full_err", {27'd0, err2}, 0);
    chk("full_mm",  {16'd0, mm2}, 16'h0000);
    chk("full_entry13", {30'd0, res2[26 +: 2]}, 2'b11);
    for (int i = 0; i < 16; i++)
      chk($sformatf("full_res%0d", tbl[i].vec), {30'd0, res2[tbl[i].vec*2 +: 2]}, {30'd0, tbl[i].yz});
    repeat (3) @(negedge clk);
    chk("hold_after_done_err", {27'd0, err2}, 0);
    chk("hold_after_done_res13", {30'd0, res2[26 +: 2]}, 2'b11);

    // Expected entry 5 corrupted
    exp2[10 +: 2] = 2'b11;
    sweep2(1'b0, "mis");
    chk("mis_mm",  {16'd0, mm2}, 16'h0020);
    chk("mis_err", {27'd0, err2}, 1);
    build_good_exp();

    // Abort at vector 7
    pulse_start2();
    begin
      int k;
      k = 0;
      while (stim2 != 4'd7 && k < 100) begin
        @(negedge clk);
        k++;
      end
      chk("abort_reach7", {31'd0, (stim2 == 4'd7)}, 1);
    end
    abort2 = 1'b1;
    @(negedge clk);
    abort2 = 1'b0;
    chk("abort_busy", {31'd0, busy2}, 0);
    chk("abort_stim", {28'd0, stim2}, 0);
    begin
      int dn;
      dn = 0;
      for (int c = 0; c < 40; c++) begin
        if (done2) dn++;
        @(negedge clk);
      end
      chk("abort_no_done", dn, 0);
    end
    for (int i = 0; i < 16; i++)
      chk($sformatf("abort_res%0d", i), {30'd0, res2[i*2 +: 2]}, (i < 7) ? {30'd0, tbl[i].yz} : 32'd0);
    chk("abort_in_idle_ignored", {31'd0, busy2}, 0);

    // Start pulses while busy, including on the final sample edge
    sweep2(1'b1, "busy_start");
    chk("busy_start_err", {27'd0, err2}, 0);

    // Mid-stream reset, with a mismatch already counted
    exp2[2 +: 2] = 2'b11;
    pulse_start2();
    repeat (9) @(negedge clk);
    chk("pre_rst_err", {27'd0, err2}, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_stim", {28'd0, stim2}, 0);
    chk("mrst_busy", {31'd0, busy2}, 0);
    chk("mrst_done", {31'd0, done2}, 0);
    chk("mrst_err",  {27'd0, err2}, 0);
    chk("mrst_res",  res2, 0);
    rst = 1'b0;
    build_good_exp();
    @(negedge clk);

    // HOLD_CYCLES=1, zero datapath against all-ones expectations
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk("h1_stim", {28'd0, stim1}, (c < 16) ? c : 0);
      chk("h1_done", {31'd0, done1}, {31'd0, (c == 16)});
      @(negedge clk);
    end
    chk("h1_err", {27'd0, err1}, 16);
    chk("h1_mm",  {16'd0, mm1}, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
